// File: rtl/systolic_sequencer.sv
// systolic_sequencer: run controller for an N x N systolic array.
//
// Accepts a start command with inner-dimension length K, issues K operand
// buffer reads, generates the diagonal skew lane enables for the west/north
// array boundaries, holds select_accumulator high while the wavefront drains,
// then pulses done for one cycle.
//
// Optional feature (compile-time macro):
//   SYSTOLIC_SEQ_B2B_EN - accept a new start in the DONE cycle, so back-to-back
//                         runs keep busy_o high with no idle gap.
//
// Parameters:
//   N        array dimension (>= 2), must match the array instance
//   K_WIDTH  width of the K length and the operand read address
//
// Ports:
//   clk_i                 clock, rising edge
//   rst_i                 asynchronous active-high reset
//   start_i               start request
//   k_len_i               inner-dimension length, sampled on an accepted start
//   abort_i               synchronous abort of the current run
//   busy_o                run in progress
//   done_o                one-cycle completion pulse
//   rd_en_o               operand buffer read enable (data returns 1 cycle later)
//   rd_addr_o             operand buffer read address
//   row_en_o              west lane enables, bit i = array row i
//   col_en_o              north lane enables, bit i = array column i
//   inputs_valid_o        array top-left inputs-valid
//   select_accumulator_o  broadcast select-accumulator for every PE
module systolic_sequencer #(
  parameter int unsigned N       = 2,
  parameter int unsigned K_WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [K_WIDTH-1:0] k_len_i,
  input  logic               abort_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               rd_en_o,
  output logic [K_WIDTH-1:0] rd_addr_o,
  output logic [N-1:0]       row_en_o,
  output logic [N-1:0]       col_en_o,
  output logic               inputs_valid_o,
  output logic               select_accumulator_o
);

  // Phase counter covers both SKEW (N cycles) and DRAIN (2N-1 cycles).
  localparam int unsigned PhW = $clog2(2 * N);
  localparam logic [PhW-1:0]     PhOne     = PhW'(1);
  localparam logic [PhW-1:0]     SkewLast  = PhW'(N - 1);
  localparam logic [PhW-1:0]     DrainLast = PhW'(2 * N - 2);
  localparam logic [K_WIDTH-1:0] KOne      = K_WIDTH'(1);

  typedef enum logic [2:0] {
    StIdle,
    StFeed,
    StSkew,
    StDrain,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [K_WIDTH-1:0] k_q, k_d;
  logic [K_WIDTH-1:0] addr_q, addr_d;
  logic [PhW-1:0]     ph_q, ph_d;
  logic [N-1:0]       chain_q, chain_d;
  logic               accept;

  assign accept = start_i && (k_len_i != '0);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    addr_d  = addr_q;
    ph_d    = ph_q;
    // Stage 0 captures rd_en, so the first lane opens when read data arrives.
    chain_d = (chain_q << 1) | N'(rd_en_o);

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StFeed;
          k_d     = k_len_i;
          addr_d  = '0;
        end
      end
      StFeed: begin
        // Compare against K-1 so K = 2^K_WIDTH-1 never wraps the address.
        if (addr_q == k_q - KOne) begin
          state_d = StSkew;
          addr_d  = '0;
          ph_d    = '0;
        end else begin
          addr_d = addr_q + KOne;
        end
      end
      StSkew: begin
        if (ph_q == SkewLast) begin
          state_d = StDrain;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + PhOne;
        end
      end
      StDrain: begin
        if (ph_q == DrainLast) begin
          state_d = StDone;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + PhOne;
        end
      end
      StDone: begin
        state_d = StIdle;
`ifdef SYSTOLIC_SEQ_B2B_EN
        if (accept) begin
          state_d = StFeed;
          k_d     = k_len_i;
          addr_d  = '0;
        end
`endif
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over everything, including a simultaneous start.
    if (abort_i && (state_q != StIdle)) begin
      state_d = StIdle;
      addr_d  = '0;
      ph_d    = '0;
      chain_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      k_q     <= '0;
      addr_q  <= '0;
      ph_q    <= '0;
      chain_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      ph_q    <= ph_d;
      chain_q <= chain_d;
    end
  end

  // Outputs decode directly from flops, so reset clears them without a clock.
  assign busy_o               = (state_q != StIdle);
  assign done_o               = (state_q == StDone);
  assign rd_en_o              = (state_q == StFeed);
  assign rd_addr_o            = addr_q;
  assign row_en_o             = chain_q;
  assign col_en_o             = chain_q;
  assign inputs_valid_o       = chain_q[0];
  assign select_accumulator_o = (state_q == StDrain);

endmodule

// File: tb/tb_systolic_sequencer.sv
module tb_systolic_sequencer;

  logic       clk;
  logic       rst;
  logic       start, abort;
  logic [7:0] k;
  logic       busy, done, rd_en, iv, sel;
  logic [7:0] addr;
  logic [1:0] row, col;

  logic       start4, abort4;
  logic [3:0] k4;
  logic       busy4, done4, rd_en4, iv4, sel4;
  logic [3:0] addr4;
  logic [1:0] row4, col4;

  int n_checks = 0;
  int n_fail   = 0;

  systolic_sequencer #(.N(2), .K_WIDTH(8)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .start_i             (start),
    .k_len_i             (k),
    .abort_i             (abort),
    .busy_o              (busy),
    .done_o              (done),
    .rd_en_o             (rd_en),
    .rd_addr_o           (addr),
    .row_en_o            (row),
    .col_en_o            (col),
    .inputs_valid_o      (iv),
    .select_accumulator_o(sel)
  );

  systolic_sequencer #(.N(2), .K_WIDTH(4)) dut4 (
    .clk_i               (clk),
    .rst_i               (rst),
    .start_i             (start4),
    .k_len_i             (k4),
    .abort_i             (abort4),
    .busy_o              (busy4),
    .done_o              (done4),
    .rd_en_o             (rd_en4),
    .rd_addr_o           (addr4),
    .row_en_o            (row4),
    .col_en_o            (col4),
    .inputs_valid_o      (iv4),
    .select_accumulator_o(sel4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [7:0]  k;
    logic [16:0] exp;
  } vec_t;

  // {busy, done, rd_en, addr[7:0], row[1:0], col[1:0], iv, sel}
  function automatic logic [16:0] pk(input logic b, input logic d, input logic r,
                                     input logic [7:0] a, input logic [1:0] rw,
                                     input logic v, input logic s);
    return {b, d, r, a, rw, rw, v, s};
  endfunction

  function automatic logic [16:0] outs();
    return {busy, done, rd_en, addr, row, col, iv, sel};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vt[13];
  int   first_done;
  logic seen;

  initial begin
    // Main K=3 run plus ignored starts; vector j applied, one edge, then checked.
    vt[0]  = '{1'b0, 8'd0, pk(0, 0, 0, 0, 2'b00, 0, 0)};
    vt[1]  = '{1'b1, 8'd0, pk(0, 0, 0, 0, 2'b00, 0, 0)};
    vt[2]  = '{1'b0, 8'd0, pk(0, 0, 0, 0, 2'b00, 0, 0)};
    vt[3]  = '{1'b1, 8'd3, pk(1, 0, 1, 0, 2'b00, 0, 0)};
    vt[4]  = '{1'b0, 8'd0, pk(1, 0, 1, 1, 2'b01, 1, 0)};
    vt[5]  = '{1'b0, 8'd0, pk(1, 0, 1, 2, 2'b11, 1, 0)};
    vt[6]  = '{1'b1, 8'd7, pk(1, 0, 0, 0, 2'b11, 1, 0)};
    vt[7]  = '{1'b0, 8'd0, pk(1, 0, 0, 0, 2'b10, 0, 0)};
    vt[8]  = '{1'b1, 8'd7, pk(1, 0, 0, 0, 2'b00, 0, 1)};
    vt[9]  = '{1'b0, 8'd0, pk(1, 0, 0, 0, 2'b00, 0, 1)};
    vt[10] = '{1'b0, 8'd0, pk(1, 0, 0, 0, 2'b00, 0, 1)};
    vt[11] = '{1'b0, 8'd0, pk(1, 1, 0, 0, 2'b00, 0, 0)};
    vt[12] = '{1'b0, 8'd0, pk(0, 0, 0, 0, 2'b00, 0, 0)};

    rst = 1'b1; start = 1'b0; k = '0; abort = 1'b0;
    start4 = 1'b0; k4 = '0; abort4 = 1'b0;
    repeat (3) tick();
    check("reset_outs", 32'(outs()), 32'h0);
    rst = 1'b0;
    tick();

    for (int j = 0; j < 13; j++) begin
      start = vt[j].start;
      k     = vt[j].k;
      tick();
      check($sformatf("vec%0d", j), 32'(outs()), 32'(vt[j].exp));
    end
    start = 1'b0; k = '0;

    // k_len=0 start held for 20 cycles: nothing moves.
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("k0_ignored", 32'(outs()), 32'h0);
    end
    start = 1'b0;
    tick();

    // Abort in the third FEED cycle of a K=5 run.
    start = 1'b1; k = 8'd5;
    tick();
    start = 1'b0; k = '0;
    tick();
    tick();
    check("abort_pre_addr", 32'(addr), 32'd2);
    abort = 1'b1; start = 1'b1; k = 8'd4;
    tick();
    abort = 1'b0; start = 1'b0; k = '0;
    check("abort_outs", 32'(outs()), 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 32'h0);
    start = 1'b1; k = 8'd1;
    tick();
    start = 1'b0; k = '0;
    for (int off = 1; off <= 8; off++) begin
      check($sformatf("k1_busy_off%0d", off), 32'(busy), 32'(off <= 7));
      check($sformatf("k1_done_off%0d", off), 32'(done), 32'(off == 7));
      if (off < 8) tick();
    end

    // Asynchronous reset in DRAIN.
    start = 1'b1; k = 8'd2;
    tick();
    start = 1'b0; k = '0;
    repeat (4) tick();
    check("pre_rst_sel", 32'(sel), 32'h1);
    #2 rst = 1'b1;
    #1 check("async_rst_outs", 32'(outs()), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    start = 1'b1; k = 8'd2;
    tick();
    start = 1'b0; k = '0;
    for (int off = 1; off <= 8; off++) begin
      if (off >= 7)
        check($sformatf("rst_k2_done_off%0d", off), 32'(done), 32'(off == 8));
      if (off < 8) tick();
    end
    tick();
    tick();

    // start held through a whole K=2 run.
    start = 1'b1; k = 8'd2;
    seen = 1'b0;
    for (int off = 1; off <= 8; off++) begin
      tick();
      if (!busy) seen = 1'b1;
    end
    check("b2b_first_busy", 32'(seen), 32'h0);
    check("b2b_first_done", 32'(done), 32'h1);
    tick();
`ifdef SYSTOLIC_SEQ_B2B_EN
    check("b2b_busy_gap", 32'(busy), 32'h1);
    check("b2b_feed_next", 32'(rd_en), 32'h1);
    check("b2b_addr0", 32'(addr), 32'h0);
`else
    check("b2b_idle_gap", 32'(busy), 32'h0);
    tick();
    check("b2b_feed_after_idle", 32'(rd_en), 32'h1);
    check("b2b_busy_after_idle", 32'(busy), 32'h1);
`endif
    start = 1'b0; k = '0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!busy) begin
        seen = 1'b1;
        break;
      end
    end
    check("b2b_second_ends", 32'(seen), 32'h1);

    // K_WIDTH=4, K=15: address reaches 14 without wrapping, done at A+21.
    start4 = 1'b1; k4 = 4'd15;
    first_done = -1;
    for (int off = 1; off <= 24; off++) begin
      tick();
      start4 = 1'b0; k4 = '0;
      if (off == 15) begin
        check("k15_addr_last", 32'(addr4), 32'd14);
        check("k15_rd_en_last", 32'(rd_en4), 32'h1);
      end
      if (off == 16) check("k15_rd_en_off", 32'(rd_en4), 32'h0);
      if (done4 && first_done < 0) first_done = off;
    end
    check("k15_done_offset", 32'(first_done), 32'd21);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
